// File: rtl/stream_pkg.sv
// Shared stream types and default field widths used by the arbiter and
// the packet buffer.
package stream_pkg;

  typedef enum logic {
    STORE,
    CUT
  } buf_state_t;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned QOS_WIDTH  = 4;

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for the packet buffer: synchronous write, asynchronous read.
// The array is deliberately not reset.
module stream_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 14,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_pkt_buffer.sv
// Store-and-forward packet buffer; releases a packet only once its last beat
// is resident, falling back to cut-through when a packet cannot fit.
module stream_pkt_buffer
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned T_QOS__WIDTH = QOS_WIDTH,
  parameter int unsigned T_ID___WIDTH = 1,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned PTR_W       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [PTR_W-1:0]        level_o,
  output logic [PTR_W-1:0]        pkt_cnt_o,
  output logic                    oversize_o
);

  localparam int unsigned AW      = PTR_W - 1;
  localparam int unsigned ENTRY_W = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;
  localparam logic [PTR_W-1:0] PtrOne = 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, pkt_cnt_q;
  buf_state_t       state_q;

  logic empty, full, wr_en, rd_en, valid;
  logic [ENTRY_W-1:0]      wr_entry, rd_entry;
  logic [T_DATA_WIDTH-1:0] head_data;
  logic [T_QOS__WIDTH-1:0] head_qos;
  logic [T_ID___WIDTH-1:0] head_id;
  logic                    head_last;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read only frees its slot for the following cycle; no write-through when full.
  assign s_ready_o = ~full;
  assign wr_en     = s_valid_i & ~full;

  assign valid = (state_q == CUT) ? ~empty : (pkt_cnt_q != '0);
  assign rd_en = valid & m_ready_i;

  assign wr_entry = {s_data_i, s_qos_i, s_id_i, s_last_i};
  assign {head_data, head_qos, head_id, head_last} = rd_entry;

  stream_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(wr_entry),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(rd_entry)
  );

  assign m_valid_o = valid;
  assign m_data_o  = valid ? head_data : '0;
  assign m_qos_o   = valid ? head_qos  : '0;
  assign m_id_o    = valid ? head_id   : '0;
  assign m_last_o  = valid & head_last;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt_o = pkt_cnt_q;

  // Full with no complete packet can never drain in store mode.
  assign oversize_o = (state_q == STORE) && full && (pkt_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      state_q   <= STORE;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end

      if ((wr_en & s_last_i) && !(rd_en & head_last)) begin
        pkt_cnt_q <= pkt_cnt_q + PtrOne;
      end else if (!(wr_en & s_last_i) && (rd_en & head_last) && (pkt_cnt_q != '0)) begin
        pkt_cnt_q <= pkt_cnt_q - PtrOne;
      end

      unique case (state_q)
        STORE: if (full && (pkt_cnt_q == '0)) state_q <= CUT;
        CUT:   if (rd_en && head_last) state_q <= STORE;
        default: state_q <= STORE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_buffer.sv
// Directed self-checking bench for stream_pkt_buffer (DEPTH=8).
module tb_stream_pkt_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic [3:0] s_qos;
  logic [0:0] s_id;
  logic       s_last, s_valid, s_ready;
  logic [7:0] m_data;
  logic [3:0] m_qos;
  logic [0:0] m_id;
  logic       m_last, m_valid, m_ready;
  logic [3:0] level, pkt_cnt;
  logic       oversize;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_pkt_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_qos_i   (s_qos),
    .s_id_i    (s_id),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_qos_o   (m_qos),
    .m_id_o    (m_id),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .level_o   (level),
    .pkt_cnt_o (pkt_cnt),
    .oversize_o(oversize)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = r;
  endtask

  logic [7:0] q[$];
  logic [7:0] nd;
  logic       exp_rdy;
  logic [7:0] held;
  int         idx;

  initial begin
    rst_n = 1'b0;
    s_qos = 4'd5;
    s_id  = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    #4;
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_eq("rst_oversize", 32'(oversize), 32'd0);
    step();

    // Single 3-beat packet
    drive(1'b1, 8'h11, 1'b0, 1'b1); #4; check_eq("t1_wait0", 32'(m_valid), 32'd0); step();
    drive(1'b1, 8'h22, 1'b0, 1'b1); #4; check_eq("t1_wait1", 32'(m_valid), 32'd0); step();
    drive(1'b1, 8'h33, 1'b1, 1'b1); #4; check_eq("t1_wait2", 32'(m_valid), 32'd0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1); #4;
    check_eq("t1_valid0", 32'(m_valid), 32'd1);
    check_eq("t1_data0", 32'(m_data), 32'h11);
    check_eq("t1_qos", 32'(m_qos), 32'd5);
    check_eq("t1_id", 32'(m_id), 32'd1);
    check_eq("t1_last0", 32'(m_last), 32'd0);
    check_eq("t1_pkt1", 32'(pkt_cnt), 32'd1);
    step(); #4;
    check_eq("t1_data1", 32'(m_data), 32'h22);
    check_eq("t1_last1", 32'(m_last), 32'd0);
    step(); #4;
    check_eq("t1_data2", 32'(m_data), 32'h33);
    check_eq("t1_last2", 32'(m_last), 32'd1);
    step(); #4;
    check_eq("t1_valid_end", 32'(m_valid), 32'd0);
    check_eq("t1_pkt0", 32'(pkt_cnt), 32'd0);
    check_eq("t1_level0", 32'(level), 32'd0);
    check_eq("t1_data_forced0", 32'(m_data), 32'd0);
    step();

    // Burst of 1-beat packets until full, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0); #4;
      check_eq("t2_fill_ready", 32'(s_ready), 32'd1);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0); #4;
    check_eq("t2_full_ready", 32'(s_ready), 32'd0);
    check_eq("t2_full_level", 32'(level), 32'd8);
    check_eq("t2_full_pkt", 32'(pkt_cnt), 32'd8);
    check_eq("t2_full_oversize", 32'(oversize), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1); #4;
      check_eq("t2_drain_valid", 32'(m_valid), 32'd1);
      check_eq("t2_drain_data", 32'(m_data), 32'h40 + 32'(i));
      check_eq("t2_drain_last", 32'(m_last), 32'd1);
      step();
    end
    #4;
    check_eq("t2_empty_valid", 32'(m_valid), 32'd0);
    check_eq("t2_empty_level", 32'(level), 32'd0);
    step();

    // Continuous write with toggling m_ready; queue model tracks contents
    nd = 8'h80;
    for (int c = 0; c < 64; c++) begin
      drive(1'b1, nd, 1'b1, c[0]); #4;
      exp_rdy = (q.size() < 8);
      check_eq("t3_ready", 32'(s_ready), 32'(exp_rdy));
      check_eq("t3_valid", 32'(m_valid), 32'(q.size() != 0));
      if (q.size() != 0 && m_ready) check_eq("t3_data", 32'(m_data), 32'(q[0]));
      step();
      if (q.size() != 0 && m_ready) void'(q.pop_front());
      if (exp_rdy) begin
        q.push_back(nd);
        nd = nd + 8'd1;
      end
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1); #4;
      check_eq("t3_drain_valid", 32'(m_valid), 32'(q.size() != 0));
      if (q.size() != 0) check_eq("t3_drain_data", 32'(m_data), 32'(q[0]));
      step();
      if (q.size() != 0) void'(q.pop_front());
    end
    #4;
    check_eq("t3_level_end", 32'(level), 32'd0);
    step();

    // Oversize 12-beat packet forces cut-through
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0); #4;
      check_eq("t4_fill_valid", 32'(m_valid), 32'd0);
      check_eq("t4_fill_oversize", 32'(oversize), 32'd0);
      step();
    end
    drive(1'b1, 8'hA8, 1'b0, 1'b0); #4;
    check_eq("t4_full_ready", 32'(s_ready), 32'd0);
    check_eq("t4_full_level", 32'(level), 32'd8);
    check_eq("t4_full_pkt", 32'(pkt_cnt), 32'd0);
    check_eq("t4_oversize_pulse", 32'(oversize), 32'd1);
    check_eq("t4_full_valid", 32'(m_valid), 32'd0);
    step();
    for (int k = 9; k <= 20; k++) begin
      idx = (k <= 10) ? 8 : k - 2;
      drive(k <= 13, 8'hA0 + 8'(idx), idx == 11, 1'b1); #4;
      check_eq("t4_cut_oversize", 32'(oversize), 32'd0);
      check_eq("t4_cut_valid", 32'(m_valid), 32'd1);
      check_eq("t4_cut_data", 32'(m_data), 32'hA0 + 32'(k - 9));
      check_eq("t4_cut_last", 32'(m_last), 32'(k == 20));
      if (k == 9) check_eq("t4_cut_ready_full", 32'(s_ready), 32'd0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0); #4;
    check_eq("t4_end_valid", 32'(m_valid), 32'd0);
    check_eq("t4_end_level", 32'(level), 32'd0);
    check_eq("t4_end_pkt", 32'(pkt_cnt), 32'd0);
    step();
    // Back in store mode a partial packet must not be released
    drive(1'b1, 8'h51, 1'b0, 1'b0); #4; step();
    drive(1'b1, 8'h52, 1'b1, 1'b0); #4;
    check_eq("t4_store_hold", 32'(m_valid), 32'd0);
    step();

    // Backpressure stability
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #4;
      check_eq("t5_bp_valid", 32'(m_valid), 32'd1);
      check_eq("t5_bp_data", 32'(m_data), 32'h51);
      check_eq("t5_bp_pkt", 32'(pkt_cnt), 32'd1);
      check_eq("t5_bp_level", 32'(level), 32'd2);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); #4;
    check_eq("t5_rel_data0", 32'(m_data), 32'h51);
    check_eq("t5_rel_last0", 32'(m_last), 32'd0);
    step(); #4;
    check_eq("t5_rel_data1", 32'(m_data), 32'h52);
    check_eq("t5_rel_last1", 32'(m_last), 32'd1);
    step(); #4;
    check_eq("t5_rel_empty", 32'(m_valid), 32'd0);
    step();

    // Mid-packet reset
    drive(1'b1, 8'h61, 1'b0, 1'b0); #4; step();
    drive(1'b1, 8'h62, 1'b0, 1'b0); #4; step();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0); #4; step();
    rst_n = 1'b1; #4;
    check_eq("t6_level", 32'(level), 32'd0);
    check_eq("t6_valid", 32'(m_valid), 32'd0);
    check_eq("t6_ready", 32'(s_ready), 32'd1);
    check_eq("t6_pkt", 32'(pkt_cnt), 32'd0);
    check_eq("t6_data_forced0", 32'(m_data), 32'd0);
    step();
    drive(1'b1, 8'h71, 1'b0, 1'b1); #4; check_eq("t6_wait0", 32'(m_valid), 32'd0); step();
    drive(1'b1, 8'h72, 1'b1, 1'b1); #4; check_eq("t6_wait1", 32'(m_valid), 32'd0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1); #4;
    held = m_data;
    check_eq("t6_data0", 32'(held), 32'h71);
    check_eq("t6_valid0", 32'(m_valid), 32'd1);
    step(); #4;
    check_eq("t6_data1", 32'(m_data), 32'h72);
    check_eq("t6_last1", 32'(m_last), 32'd1);
    step(); #4;
    check_eq("t6_empty", 32'(m_valid), 32'd0);
    check_eq("t6_level_end", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
